// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback bus between execute/decode and the register file write port
// Ports (signals): alu_valid/alu_addr/alu_data ALU result; mdu_valid/mdu_ready/mdu_addr/mdu_data MDU handshake;
//   D/D_En/D_Addr register file write port; S_Addr/T_Addr decode reads; s_pend/t_pend hazard flags; fifo_count occupancy.
interface regfile_wb_arbiter_if #(parameter int DEPTH = 4);
  logic                     alu_valid;
  logic [4:0]               alu_addr;
  logic [31:0]              alu_data;
  logic                     mdu_valid;
  logic                     mdu_ready;
  logic [4:0]               mdu_addr;
  logic [31:0]              mdu_data;
  logic [31:0]              D;
  logic                     D_En;
  logic [4:0]               D_Addr;
  logic [4:0]               S_Addr;
  logic [4:0]               T_Addr;
  logic                     s_pend;
  logic                     t_pend;
  logic [$clog2(DEPTH):0]   fifo_count;
  modport master (
    output alu_valid, alu_addr, alu_data, mdu_valid, mdu_addr, mdu_data, S_Addr, T_Addr,
    input  mdu_ready, D, D_En, D_Addr, s_pend, t_pend, fifo_count
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, mdu_valid, mdu_addr, mdu_data, S_Addr, T_Addr,
    output mdu_ready, D, D_En, D_Addr, s_pend, t_pend, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered MDU results onto the single register file write port
// Ports: clk rising-edge clock; reset async active-low; bus slave modport of regfile_wb_arbiter_if
//   (ALU/MDU inputs, registered D/D_En/D_Addr, combinational s_pend/t_pend, mdu_ready, fifo_count).
module regfile_wb_arbiter #(parameter int DEPTH = 4) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] live;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [AW:0]      count;
  logic [31:0]      d_q;
  logic             en_q;
  logic [4:0]       waddr_q;
  logic [DEPTH-1:0] hit_s, hit_t;
  logic             alu_wr, push, pop;
  assign alu_wr        = bus.alu_valid && |bus.alu_addr;
  assign bus.mdu_ready = count < (AW+1)'(DEPTH);
  assign push          = bus.mdu_valid && bus.mdu_ready && |bus.mdu_addr;
  assign pop           = !alu_wr && |count;
  assign bus.D          = d_q;
  assign bus.D_En       = en_q;
  assign bus.D_Addr     = waddr_q;
  assign bus.fifo_count = count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live    <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
      waddr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) head <= head + 1'b1;
      // live is cleared on pop too, so only occupied slots ever take part in hazard checks
      for (int i = 0; i < DEPTH; i++)
        if ((alu_wr && addr_q[i] == bus.alu_addr) || (pop && AW'(i) == head)) live[i] <= 1'b0;
      // a same-cycle push lands after the kill, so it stays live as the younger write
      if (push) begin
        live[tail]   <= 1'b1;
        addr_q[tail] <= bus.mdu_addr;
        data_q[tail] <= bus.mdu_data;
        tail         <= tail + 1'b1;
      end
      if (alu_wr) begin
        en_q    <= 1'b1;
        waddr_q <= bus.alu_addr;
        d_q     <= bus.alu_data;
      end else if (pop) begin
        en_q    <= live[head];
        waddr_q <= addr_q[head];
        d_q     <= data_q[head];
      end else
        en_q <= 1'b0;
    end
  end
  always_comb begin
    hit_s = '0;
    hit_t = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s[i] = live[i] && addr_q[i] == bus.S_Addr;
      hit_t[i] = live[i] && addr_q[i] == bus.T_Addr;
    end
  end
  assign bus.s_pend = |bus.S_Addr && ((en_q && waddr_q == bus.S_Addr) ||
                      (bus.alu_valid && bus.alu_addr == bus.S_Addr) || |hit_s);
  assign bus.t_pend = |bus.T_Addr && ((en_q && waddr_q == bus.T_Addr) ||
                      (bus.alu_valid && bus.alu_addr == bus.T_Addr) || |hit_t);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus against a queue-based writeback model
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus();
  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {bit live; logic [4:0] addr; logic [31:0] data;} ent_t;
  ent_t q[$];
  logic        exp_en = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_d = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit pend(input logic [4:0] a);
    bit p;
    p = (exp_en && exp_addr == a) || (bus.alu_valid && bus.alu_addr == a);
    foreach (q[i]) if (q[i].live && q[i].addr == a) p = 1'b1;
    return (a != 0) && p;
  endfunction
  task automatic model_reset();
    q.delete();
    exp_en = 1'b0;
    exp_addr = '0;
    exp_d = '0;
  endtask
  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad, input bit mv,
                       input logic [4:0] ma, input logic [31:0] md, input logic [4:0] s, input logic [4:0] t);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mdu_valid = mv; bus.mdu_addr = ma; bus.mdu_data = md;
    bus.S_Addr = s; bus.T_Addr = t;
  endtask
  task automatic idle(input logic [4:0] s, input logic [4:0] t);
    drive(0, 0, 0, 0, 0, 0, s, t);
  endtask
  task automatic cyc();
    bit aw, push;
    logic [4:0] aa, ma;
    logic [31:0] ad, md;
    ent_t e;
    #1;
    chk("mdu_ready", 32'(bus.mdu_ready), 32'(q.size() < DEPTH));
    chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    chk("s_pend", 32'(bus.s_pend), 32'(pend(bus.S_Addr)));
    chk("t_pend", 32'(bus.t_pend), 32'(pend(bus.T_Addr)));
    aa = bus.alu_addr; ad = bus.alu_data; ma = bus.mdu_addr; md = bus.mdu_data;
    aw = bus.alu_valid && aa != 0;
    push = bus.mdu_valid && q.size() < DEPTH && ma != 0;
    @(posedge clk);
    if (aw) foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
    if (aw) begin
      exp_en = 1'b1; exp_addr = aa; exp_d = ad;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_en = e.live; exp_addr = e.addr; exp_d = e.data;
    end else
      exp_en = 1'b0;
    if (push) q.push_back('{1'b1, ma, md});
    #1;
    chk("D_En", 32'(bus.D_En), 32'(exp_en));
    chk("D_Addr", 32'(bus.D_Addr), 32'(exp_addr));
    chk("D", bus.D, exp_d);
    @(negedge clk);
  endtask
  initial begin
    idle(0, 0);
    #2;
    chk("rst D_En", 32'(bus.D_En), 0);
    chk("rst D_Addr", 32'(bus.D_Addr), 0);
    chk("rst D", bus.D, 0);
    chk("rst fifo_count", 32'(bus.fifo_count), 0);
    chk("rst mdu_ready", 32'(bus.mdu_ready), 1);
    drive(1, 5, 32'h1234, 0, 0, 0, 5, 6);
    #1;
    chk("rst s_pend alu", 32'(bus.s_pend), 1);
    chk("rst t_pend", 32'(bus.t_pend), 0);
    idle(5, 6);
    #1;
    chk("rst s_pend idle", 32'(bus.s_pend), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // single ALU write, then bubble
    drive(1, 5, 32'h1234, 0, 0, 0, 5, 0);
    cyc();
    chk("alu D_En", 32'(bus.D_En), 1);
    idle(5, 0);
    cyc();
    chk("alu bubble D_En", 32'(bus.D_En), 0);
    // single MDU result through an empty FIFO
    drive(0, 0, 0, 1, 7, 32'hAAAA, 7, 0);
    cyc();
    idle(7, 0);
    cyc();
    chk("mdu D_Addr", 32'(bus.D_Addr), 7);
    cyc();
    // ALU starves the FIFO until full, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 3, 32'(i), 1, 5'(10 + i), 32'hB0 + 32'(i), 5'(10 + i), 3);
      cyc();
    end
    drive(1, 3, 32'h33, 1, 15, 32'hFF, 15, 12);
    cyc();
    chk("full fifo_count", 32'(bus.fifo_count), DEPTH);
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle(5'(10 + i), 13);
      cyc();
    end
    // younger ALU write kills the queued MDU write to the same register
    drive(0, 0, 0, 1, 9, 32'h1, 0, 9);
    cyc();
    drive(1, 9, 32'h2, 0, 0, 0, 0, 9);
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(0, 9);
      cyc();
    end
    // writes to r0 are never performed
    drive(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    cyc();
    idle(0, 0);
    cyc();
    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 32'h77, 1, 5'(20 + i), 32'hC0 + 32'(i), 20, 21);
      cyc();
    end
    idle(20, 21);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid rst D_En", 32'(bus.D_En), 0);
    chk("mid rst fifo_count", 32'(bus.fifo_count), 0);
    chk("mid rst mdu_ready", 32'(bus.mdu_ready), 1);
    chk("mid rst D", bus.D, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(21, 22);
      cyc();
    end
    // random traffic: a balanced phase, then an ALU-heavy phase that fills the FIFO
    for (int i = 0; i < 800; i++) begin
      int alu_pct;
      logic [4:0] pick [4];
      alu_pct = (i < 400) ? 40 : 85;
      pick[0] = 0; pick[1] = 1; pick[2] = 2; pick[3] = 9;
      drive($urandom_range(99) < alu_pct, pick[$urandom_range(3)], $urandom,
            $urandom_range(1), pick[$urandom_range(3)], $urandom,
            pick[$urandom_range(3)], pick[$urandom_range(3)]);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter that drives the single write port (D, D_En, D_Addr) of the 32x32 register file. It merges single-cycle ALU results with results from the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO, and the block reports pending writes so decode can stall on RAW hazards. It sits between the execute stage and the register file, one write per clock.

## Interface
- DEPTH, 4, MDU result FIFO entries; power of two, minimum 2.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no back-pressure.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  FIFO can accept; equals (count < DEPTH), independent of mdu_valid.
- mdu_addr  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- D  out  32  register file write data, registered.
- D_En  out  1  register file write enable, registered.
- D_Addr  out  5  register file write address, registered.
- S_Addr, T_Addr  in  5 each  decode read addresses, for hazard check.
- s_pend, t_pend  out  1 each  combinational; a write to S_Addr/T_Addr is outstanding.
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy, live plus killed entries.

## Operation
- FIFO entry = {live, addr[4:0], data[31:0]}. There are head and tail pointers plus a count; pointers wrap modulo DEPTH.
- MDU push happens when mdu_valid && mdu_ready at a rising edge. If mdu_addr == 0, the handshake completes but nothing is enqueued.
- Output register selection at each edge, in priority order:
  1. alu_valid && alu_addr != 0: load {D_En=1, D_Addr=alu_addr, D=alu_data}. FIFO is not popped.
  2. Else if the FIFO is non-empty: pop the head. Load {D_En=head.live, D_Addr=head.addr, D=head.data}. A dead head consumes the cycle with D_En=0.
  3. Else: D_En=0. D_Addr and D hold their previous values.
- alu_valid with alu_addr == 0 is treated as no ALU write, so the FIFO may pop that cycle.
- Kill rule: an ALU write to register r clears live on every entry already queued with addr r. This prevents an older MDU result from overwriting a younger ALU result.
- An MDU entry pushed in the same cycle as an ALU write to the same r is younger. It is enqueued live and is not killed.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push while full is impossible because ready is 0.
- Pop while empty is impossible; rule 3 applies.
- s_pend = (S_Addr != 0) && ((D_En && D_Addr == S_Addr) || (alu_valid && alu_addr == S_Addr) || any live entry with addr == S_Addr). t_pend is the same using T_Addr.
- Register 0 never appears with D_En=1.

## Timing
- Reset asserted, from any state including mid-drain: D_En=0, D_Addr=0, D=0, count=0, pointers=0, all live bits=0, mdu_ready=1. s_pend/t_pend depend only on alu_valid until the first edge.
- Queued data is discarded at reset. No write reaches the register file after reset assertion.
- ALU latency: alu_valid sampled at edge k gives D_En=1 after edge k. The register file commits at edge k+1.
- MDU latency, empty FIFO with no ALU traffic: pushed at edge k, popped at edge k+1, so D_En=1 after edge k+1.
- Continuous ALU writes starve the FIFO indefinitely. The pipeline guarantees bubbles; the arbiter has no starvation counter.
- mdu_ready deasserts the cycle after the push that makes count == DEPTH. It reasserts the cycle after any pop from full.

## Test plan
- Reset, then alu_valid=1, alu_addr=5, alu_data=32'h1234 for one cycle -> after that edge D_En=1, D_Addr=5, D=32'h1234; next cycle D_En=0.
- Push MDU {r7, 32'hAAAA} with alu_valid=0 -> D_En=1, D_Addr=7 two edges after the push; fifo_count goes 1 then 0.
- Hold alu_valid=1 (r3) and push 4 MDU results -> mdu_ready=0 with fifo_count=4. Drop alu_valid -> the four writes drain in push order on consecutive cycles, and mdu_ready returns to 1 after the first pop.
- Push MDU {r9, 32'h1}, then the ALU writes r9=32'h2 before the pop -> r9 written with 32'h2 only. The popped slot shows D_En=0, and t_pend with T_Addr=9 drops after the ALU write retires.
- Push MDU r0 and ALU r0 -> no D_En=1 ever. s_pend=0 for S_Addr=0. fifo_count stays 0.
- Fill the FIFO with 3 entries, then assert reset mid-drain -> D_En=0 immediately, fifo_count=0, mdu_ready=1. No further writes after release.
